// File: rtl/sm_fetch_scheduler.sv
// sm_fetch_scheduler: per-warp PC/active tracking, round-robin fetch grant, single outstanding code read.
// Optional feature macro: SM_FETCH_REDIRECT_EN makes the redirect_* ports functional.
module sm_fetch_scheduler #(
  parameter int NUM_WARP = 8,
  parameter int WID_W    = 3,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                warp_req_valid_i,
  input  logic [WID_W-1:0]    warp_req_wid_i,
  input  logic [ADDR_W-1:0]   warp_req_start_addr_i,
  input  logic                warp_done_i,
  input  logic [WID_W-1:0]    warp_done_wid_i,
  input  logic                redirect_valid_i,
  input  logic [WID_W-1:0]    redirect_wid_i,
  input  logic [ADDR_W-1:0]   redirect_pc_i,
  input  logic [NUM_WARP-1:0] inst_buffer_avail_i,
  input  logic                code_mem_available_i,
  output logic                code_read_valid_o,
  output logic [ADDR_W-1:0]   code_read_addr_o,
  output logic [WID_W-1:0]    code_read_wid_o,
  input  logic                code_read_ready_i,
  input  logic [DATA_W-1:0]   code_read_data_i,
  output logic                inst_valid_o,
  output logic [WID_W-1:0]    inst_wid_o,
  output logic [ADDR_W-1:0]   inst_pc_o,
  output logic [DATA_W-1:0]   inst_data_o,
  output logic [NUM_WARP-1:0] active_mask_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]          state;
  logic [NUM_WARP-1:0] active;
  logic [ADDR_W-1:0]   pc [NUM_WARP];
  logic [WID_W-1:0]    rr_ptr;
  logic [WID_W-1:0]    cur_wid;
  logic [ADDR_W-1:0]   cur_pc;
  logic                kill;

  logic                redir_ok;
  logic [WID_W-1:0]    redir_wid;
  logic [ADDR_W-1:0]   redir_pc;
  logic [NUM_WARP-1:0] eligible;
  logic [NUM_WARP-1:0] hit_vec;
  logic                grant_found;
  logic [WID_W-1:0]    grant_wid;
  logic [WID_W-1:0]    scan_wid;
  logic                hit_cur;
  logic                deliver;

`ifdef SM_FETCH_REDIRECT_EN
  assign redir_ok  = redirect_valid_i && active[redirect_wid_i];
  assign redir_wid = redirect_wid_i;
  assign redir_pc  = redirect_pc_i;
`else
  logic unused_redirect;
  assign unused_redirect = ^{redirect_valid_i, redirect_wid_i, redirect_pc_i};
  assign redir_ok  = 1'b0;
  assign redir_wid = '0;
  assign redir_pc  = '0;
`endif

  assign eligible = active & inst_buffer_avail_i;

  // Any event touching a warp this cycle; used to kill a fetch in flight for it.
  always_comb begin
    hit_vec = '0;
    if (warp_req_valid_i) hit_vec[warp_req_wid_i] = 1'b1;
    if (redir_ok)         hit_vec[redir_wid]      = 1'b1;
    if (warp_done_i)      hit_vec[warp_done_wid_i] = 1'b1;
  end

  always_comb begin
    grant_found = 1'b0;
    grant_wid   = '0;
    scan_wid    = '0;
    for (int i = 1; i <= NUM_WARP; i++) begin
      scan_wid = WID_W'((int'(rr_ptr) + i) % NUM_WARP);
      if (!grant_found && eligible[scan_wid]) begin
        grant_found = 1'b1;
        grant_wid   = scan_wid;
      end
    end
  end

  assign hit_cur = hit_vec[cur_wid];
  assign deliver = (state == WAIT) && code_read_ready_i && !kill && !hit_cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= WID_W'(NUM_WARP - 1);
      cur_wid <= '0;
      cur_pc  <= '0;
      kill    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            state   <= REQ;
            cur_wid <= grant_wid;
            cur_pc  <= pc[grant_wid];
            rr_ptr  <= grant_wid;
            kill    <= hit_vec[grant_wid];
          end
        end
        REQ: begin
          if (hit_cur) kill <= 1'b1;
          if (code_mem_available_i) state <= WAIT;
        end
        WAIT: begin
          if (hit_cur) kill <= 1'b1;
          if (code_read_ready_i) begin
            state <= IDLE;
            kill  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-warp update; a warp sees at most one event, activation first, then redirect, then done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= '0;
      for (int w = 0; w < NUM_WARP; w++) pc[w] <= '0;
    end else begin
      for (int w = 0; w < NUM_WARP; w++) begin
        if (warp_req_valid_i && warp_req_wid_i == WID_W'(w)) begin
          active[w] <= 1'b1;
          pc[w]     <= warp_req_start_addr_i;
        end else if (redir_ok && redir_wid == WID_W'(w)) begin
          pc[w] <= redir_pc;
        end else if (warp_done_i && warp_done_wid_i == WID_W'(w)) begin
          active[w] <= 1'b0;
        end else if (deliver && cur_wid == WID_W'(w)) begin
          pc[w] <= cur_pc + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_valid_o <= 1'b0;
      inst_wid_o   <= '0;
      inst_pc_o    <= '0;
      inst_data_o  <= '0;
    end else begin
      inst_valid_o <= deliver;
      inst_wid_o   <= deliver ? cur_wid : '0;
      inst_pc_o    <= deliver ? cur_pc : '0;
      inst_data_o  <= deliver ? code_read_data_i : '0;
    end
  end

  assign code_read_valid_o = (state == REQ);
  assign code_read_addr_o  = cur_pc;
  assign code_read_wid_o   = cur_wid;
  assign active_mask_o     = active;

endmodule

// File: tb/tb_sm_fetch_scheduler.sv
// tb_sm_fetch_scheduler: directed scenarios plus randomized traffic against a transaction-level model.
// Honours SM_FETCH_REDIRECT_EN the same way the design does.
module tb_sm_fetch_scheduler;
  localparam int NW = 8;
  localparam int WW = 3;
  localparam int AW = 32;
  localparam int DW = 64;
`ifdef SM_FETCH_REDIRECT_EN
  localparam bit REDIR = 1'b1;
`else
  localparam bit REDIR = 1'b0;
`endif

  logic          clk, rst_n;
  logic          warp_req_valid_i, warp_done_i, redirect_valid_i;
  logic [WW-1:0] warp_req_wid_i, warp_done_wid_i, redirect_wid_i;
  logic [AW-1:0] warp_req_start_addr_i, redirect_pc_i;
  logic [NW-1:0] inst_buffer_avail_i;
  logic          code_mem_available_i, code_read_valid_o, code_read_ready_i, inst_valid_o;
  logic [AW-1:0] code_read_addr_o, inst_pc_o;
  logic [WW-1:0] code_read_wid_o, inst_wid_o;
  logic [DW-1:0] code_read_data_i, inst_data_o;
  logic [NW-1:0] active_mask_o;

  sm_fetch_scheduler #(.NUM_WARP(NW), .WID_W(WW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .warp_req_valid_i(warp_req_valid_i), .warp_req_wid_i(warp_req_wid_i),
    .warp_req_start_addr_i(warp_req_start_addr_i),
    .warp_done_i(warp_done_i), .warp_done_wid_i(warp_done_wid_i),
    .redirect_valid_i(redirect_valid_i), .redirect_wid_i(redirect_wid_i), .redirect_pc_i(redirect_pc_i),
    .inst_buffer_avail_i(inst_buffer_avail_i), .code_mem_available_i(code_mem_available_i),
    .code_read_valid_o(code_read_valid_o), .code_read_addr_o(code_read_addr_o),
    .code_read_wid_o(code_read_wid_o), .code_read_ready_i(code_read_ready_i),
    .code_read_data_i(code_read_data_i), .inst_valid_o(inst_valid_o), .inst_wid_o(inst_wid_o),
    .inst_pc_o(inst_pc_o), .inst_data_o(inst_data_o), .active_mask_o(active_mask_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mem_lat = 0;
  bit extra_ready = 0;
  logic [DW-1:0] ret_data;

  // Reference model: warp table plus the one fetch in flight (0 none, 1 requesting, 2 awaiting data).
  bit            m_active[NW];
  logic [AW-1:0] m_pc[NW];
  int            m_last, m_phase, m_wid, m_age;
  logic [AW-1:0] m_addr;
  bit            m_killed;
  bit            e_inst_valid;
  logic [WW-1:0] e_inst_wid;
  logic [AW-1:0] e_inst_pc;
  logic [DW-1:0] e_inst_data;
  logic [NW-1:0] e_mask;

  function automatic bit m_hit(int w);
    return (warp_req_valid_i && int'(warp_req_wid_i) == w) ||
           (REDIR && redirect_valid_i && int'(redirect_wid_i) == w && m_active[w]) ||
           (warp_done_i && int'(warp_done_wid_i) == w);
  endfunction

  task automatic model_step();
    bit old_active[NW];
    bit deliver = 0;
    bit redir_applied = 0;
    int w;
    old_active = m_active;
    e_inst_valid = 0; e_inst_wid = '0; e_inst_pc = '0; e_inst_data = '0;
    if (m_phase == 0) begin
      for (int k = 1; k <= NW; k++) begin
        w = (m_last + k) % NW;
        if (m_active[w] && inst_buffer_avail_i[w]) begin
          m_phase = 1; m_wid = w; m_addr = m_pc[w]; m_killed = m_hit(w); m_last = w;
          break;
        end
      end
    end else if (m_phase == 1) begin
      if (m_hit(m_wid)) m_killed = 1;
      if (code_mem_available_i) begin m_phase = 2; m_age = 0; end
    end else begin
      if (m_hit(m_wid)) m_killed = 1;
      if (code_read_ready_i) begin
        if (!m_killed) begin
          deliver = 1; e_inst_valid = 1; e_inst_wid = WW'(m_wid);
          e_inst_pc = m_addr; e_inst_data = code_read_data_i;
        end
        m_phase = 0; m_killed = 0;
      end else m_age++;
    end
    if (warp_req_valid_i) begin
      m_active[warp_req_wid_i] = 1; m_pc[warp_req_wid_i] = warp_req_start_addr_i;
    end
    if (REDIR && redirect_valid_i && old_active[redirect_wid_i] &&
        !(warp_req_valid_i && warp_req_wid_i == redirect_wid_i)) begin
      m_pc[redirect_wid_i] = redirect_pc_i; redir_applied = 1;
    end
    if (warp_done_i && !(warp_req_valid_i && warp_req_wid_i == warp_done_wid_i) &&
        !(redir_applied && redirect_wid_i == warp_done_wid_i))
      m_active[warp_done_wid_i] = 0;
    if (deliver) m_pc[m_wid] = m_addr + 32'd1;
    for (int i = 0; i < NW; i++) e_mask[i] = m_active[i];
  endtask

  // One clock: drive memory response, advance the model, sample at the following falling edge.
  task automatic tick();
    code_read_ready_i = (m_phase == 2 && m_age >= mem_lat) || extra_ready;
    code_read_data_i  = {$urandom(), $urandom()};
    if (code_read_ready_i) ret_data = code_read_data_i;
    model_step();
    @(negedge clk);
    cyc++;
    warp_req_valid_i = 0; warp_done_i = 0; redirect_valid_i = 0;
    code_read_ready_i = 0; extra_ready = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    warp_req_valid_i = 0; warp_req_wid_i = '0; warp_req_start_addr_i = '0;
    warp_done_i = 0; warp_done_wid_i = '0;
    redirect_valid_i = 0; redirect_wid_i = '0; redirect_pc_i = '0;
    inst_buffer_avail_i = '1; code_mem_available_i = 1; code_read_ready_i = 0;
    code_read_data_i = '0; mem_lat = 0; extra_ready = 0;
    for (int i = 0; i < NW; i++) begin m_active[i] = 0; m_pc[i] = '0; end
    m_last = NW - 1; m_phase = 0; m_wid = 0; m_age = 0; m_addr = '0; m_killed = 0;
    e_inst_valid = 0; e_mask = '0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic activate(int w, logic [AW-1:0] a);
    warp_req_valid_i = 1; warp_req_wid_i = WW'(w); warp_req_start_addr_i = a;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_inst_valid got=%0h exp=0", inst_valid_o); end
    checks++; if (code_read_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_read_valid got=%0h exp=0", code_read_valid_o); end
    checks++; if (active_mask_o !== '0) begin failures++; $display("[TB] FAIL rst_mask got=%0h exp=0", active_mask_o); end
    checks++; if (code_read_addr_o !== '0) begin failures++; $display("[TB] FAIL rst_addr got=%0h exp=0", code_read_addr_o); end
    checks++; if ({inst_pc_o, inst_data_o, inst_wid_o} !== '0) begin failures++; $display("[TB] FAIL rst_inst_fields got=%0h/%0h exp=0", inst_pc_o, inst_data_o); end
    // abandon a read in flight, then a stray late data return must be ignored
    activate(1, 32'h55);
    for (int i = 0; i < 5 && !code_read_valid_o; i++) tick();
    tick();
    do_reset();
    checks++; if (code_read_valid_o !== 1'b0 || active_mask_o !== '0) begin failures++; $display("[TB] FAIL midflight_rst got=%0h/%0h exp=0/0", code_read_valid_o, active_mask_o); end
    extra_ready = 1;
    tick();
    checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL late_ready got=%0h exp=0", inst_valid_o); end
  endtask

  task automatic test_sequential_pcs();
    int n = 0;
    int last_cyc = 0;
    do_reset();
    activate(2, 32'h100);
    for (int i = 0; i < 30 && n < 3; i++) begin
      tick();
      if (inst_valid_o) begin
        checks++; if (inst_wid_o !== 3'd2) begin failures++; $display("[TB] FAIL seq_wid got=%0d exp=2", inst_wid_o); end
        checks++; if (inst_pc_o !== 32'h100 + n) begin failures++; $display("[TB] FAIL seq_pc got=%0h exp=%0h", inst_pc_o, 32'h100 + n); end
        checks++; if (inst_data_o !== ret_data) begin failures++; $display("[TB] FAIL seq_data got=%0h exp=%0h", inst_data_o, ret_data); end
        if (n > 0) begin
          checks++; if (cyc - last_cyc != 3) begin failures++; $display("[TB] FAIL seq_spacing got=%0d exp=3", cyc - last_cyc); end
        end
        last_cyc = cyc; n++;
      end
    end
    checks++; if (n != 3) begin failures++; $display("[TB] FAIL seq_count got=%0d exp=3", n); end
  endtask

  task automatic test_round_robin();
    int exp_order[10] = '{0, 1, 3, 0, 1, 3, 0, 3, 0, 3};
    int n = 0;
    bit prev = 0;
    do_reset();
    inst_buffer_avail_i = '0;
    activate(0, 32'h0); activate(1, 32'h1000); activate(3, 32'h3000);
    inst_buffer_avail_i = '1;
    for (int i = 0; i < 200 && n < 10; i++) begin
      tick();
      if (code_read_valid_o && !prev) begin
        checks++; if (int'(code_read_wid_o) != exp_order[n]) begin failures++; $display("[TB] FAIL rr_grant%0d got=%0d exp=%0d", n, code_read_wid_o, exp_order[n]); end
        n++;
        if (n == 6) inst_buffer_avail_i[1] = 1'b0;
      end
      prev = code_read_valid_o;
    end
    checks++; if (n != 10) begin failures++; $display("[TB] FAIL rr_count got=%0d exp=10", n); end
  endtask

  task automatic test_mem_stall();
    int accepts = 0;
    int got = 0;
    do_reset();
    code_mem_available_i = 0;
    activate(5, 32'h200);
    for (int i = 0; i < 10 && !code_read_valid_o; i++) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if ({code_read_valid_o, code_read_addr_o, code_read_wid_o} !== {1'b1, 32'h200, 3'd5}) begin
        failures++; $display("[TB] FAIL stall_hold got=%0h/%0h/%0d exp=1/200/5", code_read_valid_o, code_read_addr_o, code_read_wid_o);
      end
    end
    code_mem_available_i = 1;
    for (int i = 0; i < 12; i++) begin
      if (code_read_valid_o && code_mem_available_i) begin accepts++; inst_buffer_avail_i = '0; end
      tick();
      if (inst_valid_o) begin
        got++;
        checks++; if (inst_pc_o !== 32'h200) begin failures++; $display("[TB] FAIL stall_pc got=%0h exp=200", inst_pc_o); end
      end
    end
    checks++; if (accepts != 1 || got != 1) begin failures++; $display("[TB] FAIL stall_reads got=%0d/%0d exp=1/1", accepts, got); end
  endtask

  task automatic test_done_kill();
    int insts = 0;
    int reads = 0;
    do_reset();
    mem_lat = 4;
    activate(4, 32'h300);
    for (int i = 0; i < 10 && !code_read_valid_o; i++) tick();
    tick();
    warp_done_i = 1; warp_done_wid_i = 3'd4;
    tick();
    checks++; if (active_mask_o !== '0) begin failures++; $display("[TB] FAIL done_mask got=%0h exp=0", active_mask_o); end
    for (int i = 0; i < 15; i++) begin
      tick();
      if (inst_valid_o) insts++;
      if (code_read_valid_o) reads++;
    end
    checks++; if (insts != 0 || reads != 0) begin failures++; $display("[TB] FAIL done_kill got=%0d/%0d exp=0/0", insts, reads); end
  endtask

  task automatic test_redirect();
    logic [AW-1:0] first_pc = '1;
    logic [AW-1:0] next_addr = '1;
    bit prev = 0;
    do_reset();
    mem_lat = 3;
    activate(0, 32'h10);
    for (int i = 0; i < 10 && !code_read_valid_o; i++) tick();
    tick();
    redirect_valid_i = 1; redirect_wid_i = 3'd0; redirect_pc_i = 32'h40;
    tick();
    for (int i = 0; i < 30; i++) begin
      tick();
      if (inst_valid_o && first_pc === '1) first_pc = inst_pc_o;
      if (code_read_valid_o && !prev && next_addr === '1) next_addr = code_read_addr_o;
      prev = code_read_valid_o;
    end
    checks++; if (first_pc !== (REDIR ? 32'h40 : 32'h10)) begin failures++; $display("[TB] FAIL redir_first_pc got=%0h exp=%0h", first_pc, REDIR ? 32'h40 : 32'h10); end
    checks++; if (next_addr !== (REDIR ? 32'h40 : 32'h11)) begin failures++; $display("[TB] FAIL redir_next_addr got=%0h exp=%0h", next_addr, REDIR ? 32'h40 : 32'h11); end
  endtask

  task automatic test_pc_wrap();
    bit seen = 0;
    bit prev = 1;
    bit addr_seen = 0;
    do_reset();
    activate(7, 32'hFFFF_FFFF);
    for (int i = 0; i < 20 && !addr_seen; i++) begin
      tick();
      if (inst_valid_o && !seen) begin
        seen = 1;
        checks++; if (inst_pc_o !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL wrap_pc got=%0h exp=ffffffff", inst_pc_o); end
      end
      if (seen && code_read_valid_o && !prev) begin
        addr_seen = 1;
        checks++; if (code_read_addr_o !== 32'h0) begin failures++; $display("[TB] FAIL wrap_next got=%0h exp=0", code_read_addr_o); end
      end
      prev = code_read_valid_o;
    end
    checks++; if (!addr_seen) begin failures++; $display("[TB] FAIL wrap_timeout got=0 exp=1"); end
  endtask

  task automatic test_random();
    int base;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      inst_buffer_avail_i  = NW'($urandom());
      code_mem_available_i = ($urandom_range(0, 3) != 0);
      mem_lat = $urandom_range(0, 2);
      base = $urandom_range(0, NW - 1);
      if ($urandom_range(0, 5) == 0) begin
        warp_req_valid_i = 1; warp_req_wid_i = WW'(base);
        warp_req_start_addr_i = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom();
      end
      if ($urandom_range(0, 11) == 0) begin
        warp_done_i = 1; warp_done_wid_i = WW'((base + 1 + $urandom_range(0, 2)) % NW);
      end
      if ($urandom_range(0, 7) == 0) begin
        redirect_valid_i = 1; redirect_wid_i = WW'((base + 4 + $urandom_range(0, 2)) % NW);
        redirect_pc_i = $urandom();
      end
      tick();
      checks++; if (active_mask_o !== e_mask) begin failures++; $display("[TB] FAIL rnd_mask cyc=%0d got=%0h exp=%0h", cyc, active_mask_o, e_mask); end
      checks++; if (inst_valid_o !== e_inst_valid) begin failures++; $display("[TB] FAIL rnd_inst_valid cyc=%0d got=%0h exp=%0h", cyc, inst_valid_o, e_inst_valid); end
      if (e_inst_valid) begin
        checks++; if ({inst_wid_o, inst_pc_o, inst_data_o} !== {e_inst_wid, e_inst_pc, e_inst_data}) begin
          failures++; $display("[TB] FAIL rnd_inst cyc=%0d got=%0d/%0h/%0h exp=%0d/%0h/%0h", cyc, inst_wid_o, inst_pc_o, inst_data_o, e_inst_wid, e_inst_pc, e_inst_data);
        end
      end
      checks++; if (code_read_valid_o !== (m_phase == 1)) begin failures++; $display("[TB] FAIL rnd_read_valid cyc=%0d got=%0h exp=%0h", cyc, code_read_valid_o, m_phase == 1); end
      if (m_phase == 1) begin
        checks++; if ({code_read_addr_o, code_read_wid_o} !== {m_addr, WW'(m_wid)}) begin
          failures++; $display("[TB] FAIL rnd_read cyc=%0d got=%0h/%0d exp=%0h/%0d", cyc, code_read_addr_o, code_read_wid_o, m_addr, m_wid);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 0;
    test_reset();
    test_sequential_pcs();
    test_round_robin();
    test_mem_stall();
    test_done_kill();
    test_redirect();
    test_pc_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
